m_countdown_timer: RTL and testbench

Minutes/seconds countdown timer fed by the 1 kHz tick from the 50 000:1 prescaler (50 MHz clock domain). Consumes the prescaler's single-cycle tick, derives a 1 s time base, and holds a settable MM:SS value in BCD. Counts down to 00:00 and then raises an alarm. Outputs drive the 7-segment display stage and the buzzer.

---
 rtl/m_countdown_timer_pkg.sv | 7 +
 rtl/m_countdown_timer_if.sv | 8 +
 rtl/m_countdown_timer_bcd_pair_counter.sv | 48 ++++
 rtl/m_countdown_timer.sv | 85 ++++++++
 tb/tb_m_countdown_timer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/m_countdown_timer_pkg.sv
// pkg_timer: shared state encoding, BCD digit type and time moduli for the countdown timer
package pkg_timer;
  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_DONE} t_timer_state;
  typedef logic [3:0] t_bcd;
  localparam int C_SEC_MOD = 60;
  localparam int C_MIN_MOD = 100;
endpackage

// File: rtl/m_countdown_timer_if.sv
// m_countdown_timer_if: control pulses into the timer, BCD time and status back out
interface m_countdown_timer_if;
  logic tick, start_stop, clear, inc_min, inc_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic running, alarm;
  modport master(output tick, start_stop, clear, inc_min, inc_sec, input min_bcd, sec_bcd, running, alarm);
  modport slave(input tick, start_stop, clear, inc_min, inc_sec, output min_bcd, sec_bcd, running, alarm);
endinterface

// File: rtl/m_countdown_timer_bcd_pair_counter.sv
// m_bcd_pair_counter: two-digit BCD up/down counter wrapping at P_MOD, borrow on 00 -> max
module m_bcd_pair_counter
  import pkg_timer::*;
#(
  parameter int P_MOD = C_SEC_MOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output t_bcd hi,
  output t_bcd lo,
  output logic borrow_out
);
  localparam t_bcd C_HI_MAX = t_bcd'((P_MOD - 1) / 10);
  localparam t_bcd C_LO_MAX = t_bcd'((P_MOD - 1) % 10);
  t_bcd hi_d, lo_d;
  logic at_max, at_zero;
  assign at_max = hi == C_HI_MAX && lo == C_LO_MAX;
  assign at_zero = hi == '0 && lo == '0;
  assign borrow_out = dec && at_zero;
  // next digit pair: clear wins, then increment, then decrement
  always_comb begin
    hi_d = hi;
    lo_d = lo;
    if (clr) begin
      hi_d = '0;
      lo_d = '0;
    end else if (inc) begin
      hi_d = at_max ? '0 : lo == 4'd9 ? hi + 4'd1 : hi;
      lo_d = at_max || lo == 4'd9 ? '0 : lo + 4'd1;
    end else if (dec) begin
      hi_d = at_zero ? C_HI_MAX : lo == '0 ? hi - 4'd1 : hi;
      lo_d = at_zero ? C_LO_MAX : lo == '0 ? 4'd9 : lo - 4'd1;
    end
  end
  // digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end
endmodule

// File: rtl/m_countdown_timer.sv
// m_countdown_timer: MM:SS BCD countdown with alarm; TIMER_ALARM_TIMEOUT_EN ends the alarm after P_ALARM_SEC
module m_countdown_timer
  import pkg_timer::*;
#(
  parameter int P_TICKS_PER_SEC = 1000,
  parameter int P_ALARM_SEC = 10
) (
  input logic clk,
  input logic rst_n,
  m_countdown_timer_if.slave bus
);
  localparam int C_ALARM_TICKS = P_TICKS_PER_SEC * P_ALARM_SEC;
  localparam int C_SUB_MAX = C_ALARM_TICKS > P_TICKS_PER_SEC ? C_ALARM_TICKS : P_TICKS_PER_SEC;
  localparam int W = $clog2(C_SUB_MAX + 1);
  localparam logic [W-1:0] C_SEC_LAST = W'(P_TICKS_PER_SEC - 1);
`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam logic [W-1:0] C_ALARM_LAST = W'(C_ALARM_TICKS - 1);
`endif
  t_timer_state state, state_d;
  logic [W-1:0] sub, sub_d;
  t_bcd min_hi, min_lo, sec_hi, sec_lo;
  logic clr_time, inc_min_en, inc_sec_en, dec_sec, sec_borrow;
  logic time_zero, last_sec, sub_wrap, running_q, alarm_q;
  assign time_zero = {min_hi, min_lo, sec_hi, sec_lo} == 16'h0000;
  assign last_sec = {min_hi, min_lo, sec_hi, sec_lo} == 16'h0001;
  assign sub_wrap = sub == C_SEC_LAST;
  assign bus.min_bcd = {min_hi, min_lo};
  assign bus.sec_bcd = {sec_hi, sec_lo};
  assign bus.running = running_q;
  assign bus.alarm = alarm_q;
  m_bcd_pair_counter #(.P_MOD(C_SEC_MOD)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(inc_sec_en), .dec(dec_sec),
    .hi(sec_hi), .lo(sec_lo), .borrow_out(sec_borrow)
  );
  m_bcd_pair_counter #(.P_MOD(C_MIN_MOD)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clr_time), .inc(inc_min_en), .dec(sec_borrow),
    .hi(min_hi), .lo(min_lo), .borrow_out()
  );
  // state register; status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SET;
      running_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state <= state_d;
      running_q <= state_d == S_RUN;
      alarm_q <= state_d == S_DONE;
    end
  end
  // next state: clear beats start_stop beats tick
  always_comb begin
    state_d = state;
    if (bus.clear) state_d = S_SET;
    else
      case (state)
        S_SET:   state_d = bus.start_stop && !time_zero ? S_RUN : S_SET;
        S_RUN:   state_d = bus.start_stop ? S_PAUSE : bus.tick && sub_wrap && last_sec ? S_DONE : S_RUN;
        S_PAUSE: state_d = bus.start_stop ? S_RUN : S_PAUSE;
`ifdef TIMER_ALARM_TIMEOUT_EN
        default: state_d = bus.start_stop || (bus.tick && sub == C_ALARM_LAST) ? S_SET : S_DONE;
`else
        default: state_d = bus.start_stop ? S_SET : S_DONE;
`endif
      endcase
  end
  // datapath controls: time edits only in SET, decrements only on the wrapping tick in RUN
  always_comb begin
    clr_time = bus.clear;
    inc_sec_en = !bus.clear && !bus.start_stop && state == S_SET && bus.inc_sec;
    inc_min_en = !bus.clear && !bus.start_stop && state == S_SET && bus.inc_min;
    dec_sec = !bus.clear && !bus.start_stop && state == S_RUN && bus.tick && sub_wrap;
    sub_d = sub;
    if (bus.clear || (bus.start_stop && state != S_RUN && state != S_PAUSE)) sub_d = '0;
    else if (bus.tick && !bus.start_stop && state == S_RUN) sub_d = sub_wrap ? '0 : sub + W'(1);
`ifdef TIMER_ALARM_TIMEOUT_EN
    else if (bus.tick && state == S_DONE) sub_d = sub == C_ALARM_LAST ? '0 : sub + W'(1);
`endif
  end
  // sub-second tick counter, also the alarm window counter when the timeout is built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub <= '0;
    else sub <= sub_d;
  end
endmodule

// File: tb/tb_m_countdown_timer.sv
// tb_m_countdown_timer: directed vector table plus multi-cycle sequences, P_TICKS_PER_SEC=4, P_ALARM_SEC=2
module tb_m_countdown_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  m_countdown_timer_if bus();
  m_countdown_timer #(.P_TICKS_PER_SEC(4), .P_ALARM_SEC(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic t, ss, cl, im, is;
    logic [7:0] mn, sc;
    logic run, alm;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [7:0] mn, input logic [7:0] sc, input logic run, input logic alm);
    checks++;
    if ({bus.min_bcd, bus.sec_bcd, bus.running, bus.alarm} !== {mn, sc, run, alm}) begin
      errors++;
      $display("FAIL %s: got %h:%h running=%b alarm=%b, want %h:%h running=%b alarm=%b",
               name, bus.min_bcd, bus.sec_bcd, bus.running, bus.alarm, mn, sc, run, alm);
    end
  endtask
  task automatic step(input logic t, input logic ss, input logic cl, input logic im, input logic is);
    @(negedge clk);
    bus.tick = t;
    bus.start_stop = ss;
    bus.clear = cl;
    bus.inc_min = im;
    bus.inc_sec = is;
    @(posedge clk);
    #1;
    bus.tick = 0;
    bus.start_stop = 0;
    bus.clear = 0;
    bus.inc_min = 0;
    bus.inc_sec = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask
  initial begin
    bus.tick = 0;
    bus.start_stop = 0;
    bus.clear = 0;
    bus.inc_min = 0;
    bus.inc_sec = 0;
    tv.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0});
    tv.push_back('{0, 0, 0, 1, 1, 8'h01, 8'h02, 0, 0});
    tv.push_back('{0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h02, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0});
    tv.push_back('{1, 1, 0, 0, 0, 8'h00, 8'h02, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h01, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1});
    tv.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0});
    tv.push_back('{0, 0, 0, 1, 0, 8'h01, 8'h00, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0, 8'h01, 8'h00, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h01, 8'h00, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h01, 8'h00, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h01, 8'h00, 1, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h59, 1, 0});
    tv.push_back('{1, 1, 0, 0, 0, 8'h00, 8'h59, 0, 0});
    tv.push_back('{1, 0, 0, 0, 0, 8'h00, 8'h59, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1, 8'h00, 8'h59, 0, 0});
    tv.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h59, 1, 0});
    tv.push_back('{1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0});
    repeat (10) @(posedge clk);
    #1;
    chk("reset_hold", 8'h00, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("reset_release", 8'h00, 8'h00, 0, 0);
    foreach (tv[i]) begin
      step(tv[i].t, tv[i].ss, tv[i].cl, tv[i].im, tv[i].is);
      chk($sformatf("vec%0d", i), tv[i].mn, tv[i].sc, tv[i].run, tv[i].alm);
    end
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
    chk("sec_wrap_60", 8'h00, 8'h00, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("sec_wrap_61", 8'h00, 8'h01, 0, 0);
    for (int i = 0; i < 99; i++) step(0, 0, 0, 1, 0);
    chk("min_99", 8'h99, 8'h01, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("min_wrap_100", 8'h00, 8'h01, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ticks(4);
    chk("borrow_10_00", 8'h09, 8'h59, 1, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(2);
    step(0, 1, 0, 0, 0);
    chk("pause", 8'h00, 8'h05, 0, 0);
    ticks(10);
    chk("pause_hold", 8'h00, 8'h05, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("resume", 8'h00, 8'h05, 1, 0);
    ticks(1);
    chk("resume_tick1", 8'h00, 8'h05, 1, 0);
    ticks(1);
    chk("resume_tick2", 8'h00, 8'h04, 1, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(1);
    step(0, 0, 1, 0, 0);
    chk("clear_run", 8'h00, 8'h00, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("start_after_clear", 8'h00, 8'h00, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(4);
    chk("done_entry", 8'h00, 8'h00, 0, 1);
`ifdef TIMER_ALARM_TIMEOUT_EN
    ticks(7);
    chk("alarm_tick7", 8'h00, 8'h00, 0, 1);
    ticks(1);
    chk("alarm_timeout", 8'h00, 8'h00, 0, 0);
`else
    ticks(100);
    chk("alarm_hold", 8'h00, 8'h00, 0, 1);
    step(0, 1, 0, 0, 0);
    chk("alarm_ack", 8'h00, 8'h00, 0, 0);
`endif
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    ticks(2);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset", 8'h00, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 1, 0, 0, 0);
    chk("after_reset_start", 8'h00, 8'h00, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
